// File: rtl/aor_sweep_pkg.sv
// aor_sweep_pkg: sweep FSM states and width helpers for aor_key_sweep_ctrl
package aor_sweep_pkg;
  typedef enum logic [3:0] {
    IDLE, KEY_RD, KEY_LD, RD_A, RD_B, APPLY, WAIT, CHECK, REPORT, DONE
  } state_t;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int addr_w(input int num_pairs);
    return clog2_min1(2 * num_pairs);
  endfunction
  function automatic int err_w(input int num_pairs);
    return clog2_min1(num_pairs + 1);
  endfunction
  function automatic int hd_w(input int num_pairs, input int width);
    return clog2_min1(num_pairs * (width + 1) + 1);
  endfunction
endpackage

// File: rtl/aor_popcount.sv
// aor_popcount: number of set bits in an N-bit vector
module aor_popcount #(
  parameter int N  = 17,
  parameter int CW = 5
) (
  input  logic [N-1:0]  bits,
  output logic [CW-1:0] count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) count = count + CW'(bits[i]);
  end
endmodule

// File: rtl/aor_key_sweep_ctrl.sv
// aor_key_sweep_ctrl: replays operand pairs per key into locked/golden adders and reports mismatches
// AOR_SWEEP_HAMMING_EN adds a summed bit Hamming distance to each report
module aor_key_sweep_ctrl
  import aor_sweep_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int KEY_WIDTH = 32,
  parameter int NUM_PAIRS = 5000,
  parameter int NUM_KEYS  = 16,
  parameter int SETTLE    = 1,
  localparam int AW = addr_w(NUM_PAIRS),
  localparam int KW = clog2_min1(NUM_KEYS),
  localparam int EW = err_w(NUM_PAIRS),
  localparam int HW = hd_w(NUM_PAIRS, WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 mem_rd_o,
  output logic [AW-1:0]        mem_addr_o,
  input  logic [WIDTH-1:0]     mem_data_i,
  output logic                 key_rd_o,
  output logic [KW-1:0]        key_idx_o,
  input  logic [KEY_WIDTH-1:0] key_data_i,
  output logic [WIDTH-1:0]     add1_o,
  output logic [WIDTH-1:0]     add2_o,
  output logic [KEY_WIDTH-1:0] keyinput_o,
  input  logic [WIDTH:0]       result_i,
  input  logic [WIDTH:0]       golden_i,
  output logic                 rpt_valid_o,
  input  logic                 rpt_ready_i,
  output logic [KW-1:0]        rpt_key_idx_o,
  output logic [EW-1:0]        rpt_err_o,
  output logic [HW-1:0]        rpt_hd_o
);
  localparam int PW  = clog2_min1(NUM_PAIRS);
  localparam int WCW = clog2_min1(SETTLE);
  state_t         state;
  logic [KW-1:0]  k;
  logic [PW-1:0]  i;
  logic [WCW-1:0] wcnt;
  logic [WIDTH-1:0] a;
  logic [EW-1:0]  err;
  logic [HW-1:0]  hd, pc;
  logic           mis;
  assign mis = result_i != golden_i;
`ifdef AOR_SWEEP_HAMMING_EN
  localparam int PCW = clog2_min1(WIDTH + 2);
  logic [PCW-1:0] cnt;
  aor_popcount #(.N(WIDTH + 1), .CW(PCW)) u_pc (.bits(result_i ^ golden_i), .count(cnt));
  assign pc = HW'(cnt);
`else
  assign pc = '0;
`endif
  // Strobes and addresses are registered on entry to the state that owns them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      mem_rd_o      <= 1'b0;
      mem_addr_o    <= '0;
      key_rd_o      <= 1'b0;
      key_idx_o     <= '0;
      add1_o        <= '0;
      add2_o        <= '0;
      keyinput_o    <= '0;
      rpt_valid_o   <= 1'b0;
      rpt_key_idx_o <= '0;
      rpt_err_o     <= '0;
      rpt_hd_o      <= '0;
      k             <= '0;
      i             <= '0;
      wcnt          <= '0;
      a             <= '0;
      err           <= '0;
      hd            <= '0;
    end else begin
      mem_rd_o   <= 1'b0;
      mem_addr_o <= '0;
      key_rd_o   <= 1'b0;
      key_idx_o  <= '0;
      done_o     <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          state    <= KEY_RD;
          busy_o   <= 1'b1;
          k        <= '0;
          key_rd_o <= 1'b1;
        end
        KEY_RD: state <= KEY_LD;
        KEY_LD: begin
          keyinput_o <= key_data_i;
          err        <= '0;
          hd         <= '0;
          i          <= '0;
          mem_rd_o   <= 1'b1;
          state      <= RD_A;
        end
        RD_A: begin
          mem_rd_o   <= 1'b1;
          mem_addr_o <= AW'(2 * i + 1);
          state      <= RD_B;
        end
        RD_B: begin
          a     <= mem_data_i;
          state <= APPLY;
        end
        APPLY: begin
          add1_o <= a;
          add2_o <= mem_data_i;
          wcnt   <= '0;
          state  <= SETTLE > 1 ? WAIT : CHECK;
        end
        WAIT: begin
          wcnt <= wcnt + 1'b1;
          if (wcnt == WCW'(SETTLE - 2)) state <= CHECK;
        end
        CHECK: begin
          err <= err + EW'(mis);
          hd  <= hd + pc;
          if (i == PW'(NUM_PAIRS - 1)) begin
            rpt_valid_o   <= 1'b1;
            rpt_key_idx_o <= k;
            rpt_err_o     <= err + EW'(mis);
            rpt_hd_o      <= hd + pc;
            state         <= REPORT;
          end else begin
            i          <= i + 1'b1;
            mem_rd_o   <= 1'b1;
            mem_addr_o <= AW'(2 * i + 2);
            state      <= RD_A;
          end
        end
        REPORT: if (rpt_ready_i) begin
          rpt_valid_o <= 1'b0;
          if (k == KW'(NUM_KEYS - 1)) begin
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            k         <= k + 1'b1;
            key_rd_o  <= 1'b1;
            key_idx_o <= k + 1'b1;
            state     <= KEY_RD;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aor_key_sweep_ctrl.sv
// tb_aor_key_sweep_ctrl: randomized sweeps of aor_key_sweep_ctrl against a per-key mismatch model
module tb_aor_key_sweep_ctrl;
  localparam int NP = 4, NK = 2, AW = 3, KW = 1, EW = 3, HW = 7;
  localparam logic [31:0] MAGIC = 32'h96DE5F1F;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, rpt_ready = 1'b0;
  logic busy, done, mem_rd, key_rd, rpt_valid;
  logic [AW-1:0] mem_addr;
  logic [15:0] mem_data, add1, add2;
  logic [KW-1:0] key_idx, rpt_key_idx;
  logic [31:0] key_data, keyinput;
  logic [16:0] result, golden;
  logic [EW-1:0] rpt_err;
  logic [HW-1:0] rpt_hd;
  logic [15:0] ram [2*NP];
  logic [31:0] keys [NK];
  int lock_mode = 0;
  int checks = 0, passed = 0;

  // mode 0: wrong key flips bit0; mode 1: wrong key flips operand-A bits selected by key difference
  function automatic logic [16:0] locked_f(input logic [15:0] a, b, input logic [31:0] key, input int mode);
    logic [31:0] d;
    logic [16:0] g;
    d = key ^ MAGIC;
    g = {1'b0, a} + {1'b0, b};
    return mode == 0 ? g ^ 17'(d != 0) : g ^ {1'b0, a & d[15:0]};
  endfunction

  assign golden = {1'b0, add1} + {1'b0, add2};
  assign result = locked_f(add1, add2, keyinput, lock_mode);
  always @(posedge clk) begin
    if (mem_rd) mem_data <= ram[mem_addr];
    if (key_rd) key_data <= keys[key_idx];
  end
  always #5 clk = ~clk;

  aor_key_sweep_ctrl #(.WIDTH(16), .KEY_WIDTH(32), .NUM_PAIRS(NP), .NUM_KEYS(NK), .SETTLE(1)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
    .key_rd_o(key_rd), .key_idx_o(key_idx), .key_data_i(key_data),
    .add1_o(add1), .add2_o(add2), .keyinput_o(keyinput),
    .result_i(result), .golden_i(golden),
    .rpt_valid_o(rpt_valid), .rpt_ready_i(rpt_ready), .rpt_key_idx_o(rpt_key_idx),
    .rpt_err_o(rpt_err), .rpt_hd_o(rpt_hd)
  );

  task automatic fill_ram();
    for (int j = 0; j < 2 * NP; j++) ram[j] = 16'($urandom);
  endtask

  task automatic run_sweep(input bit timing, input bit poke, input bit hold);
    int exp_err [NK];
    int exp_hd [NK];
    int cnt;
    for (int k = 0; k < NK; k++) begin
      exp_err[k] = 0;
      exp_hd[k] = 0;
      for (int p = 0; p < NP; p++) begin
        logic [16:0] g, l;
        g = {1'b0, ram[2*p]} + {1'b0, ram[2*p+1]};
        l = locked_f(ram[2*p], ram[2*p+1], keys[k], lock_mode);
        exp_err[k] += int'(l != g);
`ifdef AOR_SWEEP_HAMMING_EN
        exp_hd[k] += $countones(l ^ g);
`endif
      end
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++;
    if ({key_rd, key_idx} !== {1'b1, KW'(0)}) $display("FAIL first_key_read: got rd=%0b idx=%0d want rd=1 idx=0", key_rd, key_idx);
    else passed++;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, AW'(0)}) $display("FAIL first_mem_read: got rd=%0b addr=%0d want rd=1 addr=0", mem_rd, mem_addr);
    else passed++;
    cnt = 2;
    for (int k = 0; k < NK; k++) begin
      while (!rpt_valid && cnt < 200) begin
        if (poke) start = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        cnt++;
      end
      start = 1'b0;
      if (cnt >= 200) begin
        checks++;
        $display("FAIL report_timeout: key %0d got no rpt_valid within 200 cycles", k);
        return;
      end
      if (timing && k == 0) begin
        checks++;
        if (cnt !== 18) $display("FAIL first_report_latency: got %0d cycles want 18", cnt);
        else passed++;
      end
      checks++;
      if ({rpt_key_idx, rpt_err, rpt_hd, keyinput} !== {KW'(k), EW'(exp_err[k]), HW'(exp_hd[k]), keys[k]})
        $display("FAIL report_fields: key %0d got idx=%0d err=%0d hd=%0d keyin=%h want idx=%0d err=%0d hd=%0d keyin=%h",
                 k, rpt_key_idx, rpt_err, rpt_hd, keyinput, k, exp_err[k], exp_hd[k], keys[k]);
      else passed++;
      repeat (hold ? 10 : $urandom_range(0, 3)) begin
        @(negedge clk);
        checks++;
        if ({rpt_valid, mem_rd, key_rd, key_idx, rpt_key_idx, rpt_err, rpt_hd, keyinput} !==
            {3'b100, KW'(0), KW'(k), EW'(exp_err[k]), HW'(exp_hd[k]), keys[k]})
          $display("FAIL stall_hold: key %0d got valid=%0b mrd=%0b krd=%0b kidx=%0d err=%0d hd=%0d keyin=%h want valid=1 no reads err=%0d hd=%0d keyin=%h",
                   k, rpt_valid, mem_rd, key_rd, key_idx, rpt_err, rpt_hd, keyinput, exp_err[k], exp_hd[k], keys[k]);
        else passed++;
      end
      rpt_ready = 1'b1;
      @(negedge clk);
      rpt_ready = 1'b0;
      checks++;
      if ({rpt_valid, done} !== {1'b0, k == NK - 1}) $display("FAIL after_accept: key %0d got valid=%0b done=%0b want valid=0 done=%0b", k, rpt_valid, done, k == NK - 1);
      else passed++;
      cnt = 0;
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) $display("FAIL sweep_end: got done=%0b busy=%0b want 0 0", done, busy);
    else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, mem_rd, key_rd, rpt_valid, mem_addr, key_idx, rpt_key_idx} !== '0)
      $display("FAIL reset_ctrl: got busy=%0b done=%0b mrd=%0b krd=%0b valid=%0b want all 0", busy, done, mem_rd, key_rd, rpt_valid);
    else passed++;
    checks++;
    if ({add1, add2, keyinput, rpt_err, rpt_hd} !== '0)
      $display("FAIL reset_data: got add1=%h add2=%h keyin=%h err=%0d hd=%0d want all 0", add1, add2, keyinput, rpt_err, rpt_hd);
    else passed++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, rpt_valid} !== 2'b00) $display("FAIL idle_after_reset: got busy=%0b valid=%0b want 0 0", busy, rpt_valid);
    else passed++;
  endtask

  task automatic test_golden();
    lock_mode = 0;
    keys[0] = MAGIC;
    keys[1] = MAGIC;
    fill_ram();
    run_sweep(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_directed_keys();
    lock_mode = 0;
    keys[0] = 32'h96DE5F1F;
    keys[1] = 32'h96DE5F0F;
    fill_ram();
    run_sweep(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    lock_mode = 1;
    repeat (6) begin
      for (int k = 0; k < NK; k++) keys[k] = $urandom_range(0, 2) == 0 ? MAGIC : MAGIC ^ (32'($urandom) & 32'h0000_FFFF);
      fill_ram();
      run_sweep(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    lock_mode = 1;
    keys[0] = MAGIC ^ 32'h0000_00F0;
    keys[1] = MAGIC;
    fill_ram();
    run_sweep(1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_busy_start();
    lock_mode = 0;
    keys[0] = MAGIC ^ 32'h1;
    keys[1] = MAGIC;
    fill_ram();
    run_sweep(1'b0, 1'b1, 1'b0);
    repeat (10) begin
      @(negedge clk);
      checks++;
      if ({busy, rpt_valid} !== 2'b00) $display("FAIL no_restart: got busy=%0b valid=%0b want 0 0", busy, rpt_valid);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    lock_mode = 1;
    keys[0] = MAGIC ^ 32'h0000_0F0F;
    keys[1] = MAGIC ^ 32'h0000_8001;
    fill_ram();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cnt = 0;
    while (!(mem_rd && mem_addr == AW'(4)) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt >= 100) $display("FAIL reach_pair2: got no read of addr 4 within 100 cycles");
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, mem_rd, key_rd, rpt_valid, mem_addr, key_idx, add1, add2, keyinput, rpt_key_idx, rpt_err, rpt_hd} !== '0)
      $display("FAIL mid_reset_outputs: got busy=%0b mrd=%0b addr=%0d add1=%h keyin=%h want all 0", busy, mem_rd, mem_addr, add1, keyinput);
    else passed++;
    run_sweep(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_golden();
    test_directed_keys();
    test_random();
    test_backpressure();
    test_busy_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
